port_resp_arb: RTL and testbench

PORT_RESP_ARB -- requirements
Module: port_resp_arb

---
 rtl/port_resp_arb.sv | 162 ++++++++++++++++
 tb/tb_port_resp_arb.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/port_resp_arb.sv
// rtl/port_resp_arb.sv - round-robin response arbiter for one output port
// Optional BUSY watchdog enabled by defining PORT_ARB_TIMEOUT_EN.
module port_resp_arb #(
   parameter int PORTNUM = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic [PORTNUM-1:0]         i_req,
   input  logic                       i_full,
   input  logic                       i_done,
   output logic [PORTNUM-1:0]         o_resp,
   output logic [PORTNUM-1:0]         o_nresp,
   output logic [$clog2(PORTNUM)-1:0] o_grant_port,
   output logic                       o_grant_vld,
   output logic                       o_port_ready,
   output logic                       o_timeout
);

   localparam int PW = $clog2(PORTNUM);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t             state, state_nx;
   logic [PW-1:0]      rr_ptr, rr_nx;
   logic [PORTNUM-1:0] resp_nx, nresp_nx;
   logic [PW-1:0]      gport_nx;
   logic               gvld_nx;
   logic               ready_nx;

   logic [PORTNUM-1:0] req_rot;
   logic [PW-1:0]      win_off;
   logic [PW:0]        win_sum;
   logic [PW-1:0]      win_idx;
   logic [PW:0]        nxt_sum;
   logic [PW-1:0]      nxt_idx;

`ifdef PORT_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt, cnt_nx;
   logic          tmo_nx;
`endif

   // Rotate so bit 0 is the port at rr_ptr; the lowest set bit is the winner.
   assign req_rot = PORTNUM'({i_req, i_req} >> rr_ptr);

   always_comb begin
      win_off = '0;
      for (int i = PORTNUM - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            win_off = PW'(i);
         end
      end
      win_sum = {1'b0, rr_ptr} + {1'b0, win_off};
      if (win_sum >= (PW + 1)'(PORTNUM)) begin
         win_sum = win_sum - (PW + 1)'(PORTNUM);
      end
      win_idx = win_sum[PW-1:0];
      nxt_sum = {1'b0, win_idx} + (PW + 1)'(1);
      if (nxt_sum >= (PW + 1)'(PORTNUM)) begin
         nxt_sum = '0;
      end
      nxt_idx = nxt_sum[PW-1:0];
   end

   always_comb begin
      state_nx = state;
      rr_nx    = rr_ptr;
      resp_nx  = '0;
      nresp_nx = '0;
      gport_nx = o_grant_port;
      gvld_nx  = o_grant_vld;
`ifdef PORT_ARB_TIMEOUT_EN
      cnt_nx   = cnt;
      tmo_nx   = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            if (|i_req) begin
               if (i_full) begin
                  nresp_nx = i_req;
                  state_nx = ST_HOLD;
               end else begin
                  resp_nx  = PORTNUM'(1) << win_idx;
                  gport_nx = win_idx;
                  gvld_nx  = 1'b1;
                  rr_nx    = nxt_idx;
                  state_nx = ST_BUSY;
`ifdef PORT_ARB_TIMEOUT_EN
                  cnt_nx   = '0;
`endif
               end
            end
         end
         ST_BUSY: begin
            if (i_done) begin
               gport_nx = '0;
               gvld_nx  = 1'b0;
               state_nx = ST_HOLD;
            end
`ifdef PORT_ARB_TIMEOUT_EN
            else if (cnt == CW'(TIMEOUT - 1)) begin
               tmo_nx   = 1'b1;
               gport_nx = '0;
               gvld_nx  = 1'b0;
               state_nx = ST_HOLD;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
`endif
         end
         ST_HOLD: begin
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
            gport_nx = '0;
            gvld_nx  = 1'b0;
         end
      endcase
      ready_nx = (state_nx == ST_IDLE) && !i_full;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= ST_IDLE;
         rr_ptr       <= '0;
         o_resp       <= '0;
         o_nresp      <= '0;
         o_grant_port <= '0;
         o_grant_vld  <= 1'b0;
         o_port_ready <= 1'b0;
      end else begin
         state        <= state_nx;
         rr_ptr       <= rr_nx;
         o_resp       <= resp_nx;
         o_nresp      <= nresp_nx;
         o_grant_port <= gport_nx;
         o_grant_vld  <= gvld_nx;
         o_port_ready <= ready_nx;
      end
   end

`ifdef PORT_ARB_TIMEOUT_EN
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt       <= '0;
         o_timeout <= 1'b0;
      end else begin
         cnt       <= cnt_nx;
         o_timeout <= tmo_nx;
      end
   end
`else
   assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_port_resp_arb.sv
// tb/tb_port_resp_arb.sv - self-checking bench for port_resp_arb
// Watchdog scenario is built only when PORT_ARB_TIMEOUT_EN is defined.
module tb_port_resp_arb;

`ifdef PORT_ARB_TIMEOUT_EN
   localparam int TMO = 8;
`else
   localparam int TMO = 1024;
`endif

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [15:0] i_req;
   logic        i_full;
   logic        i_done;
   logic [15:0] o_resp;
   logic [15:0] o_nresp;
   logic [3:0]  o_grant_port;
   logic        o_grant_vld;
   logic        o_port_ready;
   logic        o_timeout;

   int n_checks = 0;
   int n_pass   = 0;
   int rr       = 0;

   port_resp_arb #(.PORTNUM(16), .TIMEOUT(TMO)) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_req        (i_req),
      .i_full       (i_full),
      .i_done       (i_done),
      .o_resp       (o_resp),
      .o_nresp      (o_nresp),
      .o_grant_port (o_grant_port),
      .o_grant_vld  (o_grant_vld),
      .o_port_ready (o_port_ready),
      .o_timeout    (o_timeout)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask

   // Reference: first requester at or after the pointer, modulo the port count.
   function automatic int model_winner(input logic [15:0] r, input int p);
      for (int i = 0; i < 16; i++) begin
         if (r[(p + i) % 16]) return (p + i) % 16;
      end
      return -1;
   endfunction

   task automatic do_reset;
      i_rst = 1'b1; i_req = '0; i_full = 1'b0; i_done = 1'b0;
      tick; tick;
      i_rst = 1'b0;
      rr = 0;
   endtask

   task automatic grant_round(input logic [15:0] r, input logic [15:0] busy_req,
                              input int busy_cyc, input string tag);
      int w;
      logic [15:0] exp_oh;
      w = model_winner(r, rr);
      exp_oh = 16'(1) << w;
      i_req = r; i_full = 1'b0;
      tick;
      n_checks++;
      if ({o_resp, o_nresp, o_grant_port, o_grant_vld} !== {exp_oh, 16'h0, 4'(w), 1'b1})
         $display("FAIL %s_grant: resp=%h nresp=%h port=%0d vld=%b want resp=%h port=%0d vld=1",
                  tag, o_resp, o_nresp, o_grant_port, o_grant_vld, exp_oh, w);
      else n_pass++;
      rr = (w + 1) % 16;
      i_req = busy_req;
      for (int c = 0; c < busy_cyc; c++) begin
         i_full = 1'($urandom_range(0, 1));
         tick;
         n_checks++;
         if ({o_resp, o_nresp, o_grant_port, o_grant_vld, o_timeout} !== {32'h0, 4'(w), 1'b1, 1'b0})
            $display("FAIL %s_busy: resp=%h nresp=%h port=%0d vld=%b tmo=%b want quiet port=%0d vld=1",
                     tag, o_resp, o_nresp, o_grant_port, o_grant_vld, o_timeout, w);
         else n_pass++;
      end
      i_done = 1'b1; i_full = 1'b0;
      tick;
      i_done = 1'b0;
      n_checks++;
      if ({o_resp, o_nresp, o_grant_port, o_grant_vld} !== 37'h0)
         $display("FAIL %s_done: resp=%h nresp=%h port=%0d vld=%b want all 0",
                  tag, o_resp, o_nresp, o_grant_port, o_grant_vld);
      else n_pass++;
      tick;
      n_checks++;
      if ({o_resp, o_nresp, o_port_ready} !== {32'h0, 1'b1})
         $display("FAIL %s_hold: resp=%h nresp=%h ready=%b want 0 0 1",
                  tag, o_resp, o_nresp, o_port_ready);
      else n_pass++;
   endtask

   task automatic reject_round(input logic [15:0] r, input string tag);
      i_req = r; i_full = 1'b1;
      tick;
      n_checks++;
      if ({o_resp, o_nresp, o_grant_vld} !== {16'h0, r, 1'b0})
         $display("FAIL %s_nresp: resp=%h nresp=%h vld=%b want resp=0 nresp=%h vld=0",
                  tag, o_resp, o_nresp, o_grant_vld, r);
      else n_pass++;
      i_req = '0;
      tick;
      n_checks++;
      if ({o_resp, o_nresp} !== 32'h0)
         $display("FAIL %s_once: resp=%h nresp=%h want 0 0", tag, o_resp, o_nresp);
      else n_pass++;
      i_full = 1'b0;
   endtask

   task automatic test_reset;
      i_rst = 1'b1; i_req = 16'hFFFF; i_full = 1'b0; i_done = 1'b1;
      tick; tick;
      n_checks++;
      if ({o_resp, o_nresp, o_grant_port, o_grant_vld, o_timeout, o_port_ready} !== 39'h0)
         $display("FAIL reset_outputs: resp=%h nresp=%h port=%0d vld=%b tmo=%b ready=%b want all 0",
                  o_resp, o_nresp, o_grant_port, o_grant_vld, o_timeout, o_port_ready);
      else n_pass++;
      i_rst = 1'b0; i_req = '0; i_done = 1'b0;
      rr = 0;
      tick;
      n_checks++;
      if (o_port_ready !== 1'b1)
         $display("FAIL reset_ready: ready=%b want 1", o_port_ready);
      else n_pass++;
   endtask

   task automatic test_single;
      do_reset;
      grant_round(16'h0001, 16'h0000, 2, "single");
   endtask

   task automatic test_rr_order;
      do_reset;
      grant_round(16'h8081, 16'h8081, 1, "rr0");
      grant_round(16'h8081, 16'h8081, 1, "rr7");
      grant_round(16'h8081, 16'h8081, 1, "rr15");
      grant_round(16'h8081, 16'h8081, 1, "rr_wrap");
      n_checks++;
      if (rr !== 1) $display("FAIL rr_model_ptr: ptr=%0d want 1", rr);
      else n_pass++;
   endtask

   task automatic test_reject;
      do_reset;
      reject_round(16'h0300, "reject");
   endtask

   task automatic test_full_during_busy;
      do_reset;
      i_req = 16'h0008;
      tick;
      n_checks++;
      if ({o_resp, o_grant_port, o_grant_vld} !== {16'h0008, 4'd3, 1'b1})
         $display("FAIL fb_grant3: resp=%h port=%0d vld=%b want 0008 3 1", o_resp, o_grant_port, o_grant_vld);
      else n_pass++;
      i_req = 16'hFFFF; i_full = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick;
         n_checks++;
         if ({o_resp, o_nresp, o_grant_port, o_grant_vld} !== {32'h0, 4'd3, 1'b1})
            $display("FAIL fb_busy_quiet: resp=%h nresp=%h port=%0d vld=%b want 0 0 3 1",
                     o_resp, o_nresp, o_grant_port, o_grant_vld);
         else n_pass++;
      end
      i_done = 1'b1;
      tick;
      i_done = 1'b0;
      i_req = 16'hFFF7;
      tick;
      n_checks++;
      if ({o_resp, o_nresp, o_grant_vld} !== 33'h0)
         $display("FAIL fb_hold_quiet: resp=%h nresp=%h vld=%b want 0", o_resp, o_nresp, o_grant_vld);
      else n_pass++;
      tick;
      n_checks++;
      if ({o_resp, o_nresp} !== {16'h0, 16'hFFF7})
         $display("FAIL fb_nresp: resp=%h nresp=%h want 0000 fff7", o_resp, o_nresp);
      else n_pass++;
      i_req = '0; i_full = 1'b0;
      tick;
   endtask

   task automatic test_reset_mid_busy;
      do_reset;
      i_req = 16'h0020;
      tick;
      n_checks++;
      if ({o_resp, o_grant_port, o_grant_vld} !== {16'h0020, 4'd5, 1'b1})
         $display("FAIL rmb_grant5: resp=%h port=%0d vld=%b want 0020 5 1", o_resp, o_grant_port, o_grant_vld);
      else n_pass++;
      i_req = '0;
      tick;
      i_rst = 1'b1;
      tick;
      n_checks++;
      if ({o_resp, o_nresp, o_grant_port, o_grant_vld, o_timeout, o_port_ready} !== 39'h0)
         $display("FAIL rmb_abort: resp=%h nresp=%h port=%0d vld=%b tmo=%b ready=%b want all 0",
                  o_resp, o_nresp, o_grant_port, o_grant_vld, o_timeout, o_port_ready);
      else n_pass++;
      i_rst = 1'b0;
      rr = 0;
      grant_round(16'h0021, 16'h0020, 1, "rmb_after");
   endtask

   task automatic test_done_idle;
      do_reset;
      i_done = 1'b1;
      tick;
      i_done = 1'b0;
      tick;
      n_checks++;
      if ({o_resp, o_nresp, o_grant_vld, o_port_ready} !== {33'h0, 1'b1})
         $display("FAIL done_idle: resp=%h nresp=%h vld=%b ready=%b want 0 0 0 1",
                  o_resp, o_nresp, o_grant_vld, o_port_ready);
      else n_pass++;
   endtask

   task automatic test_random;
      logic [15:0] r;
      int w;
      do_reset;
      for (int n = 0; n < 40; n++) begin
         r = 16'($urandom) & 16'($urandom);
         if (n % 9 == 0) r = '0;
         if (r == '0) begin
            i_req = '0; i_full = 1'b0;
            tick;
            n_checks++;
            if ({o_resp, o_nresp, o_grant_vld} !== 33'h0)
               $display("FAIL rand_idle: resp=%h nresp=%h vld=%b want 0", o_resp, o_nresp, o_grant_vld);
            else n_pass++;
         end else if ($urandom_range(0, 3) == 0) begin
            reject_round(r, "rand_rej");
         end else begin
            w = model_winner(r, rr);
            grant_round(r, (r & ~(16'(1) << w)) | 16'($urandom), $urandom_range(0, 3), "rand");
         end
      end
   endtask

`ifdef PORT_ARB_TIMEOUT_EN
   task automatic test_timeout;
      do_reset;
      i_req = 16'h0001;
      tick;
      i_req = '0;
      for (int k = 1; k <= 8; k++) begin
         tick;
         n_checks++;
         if ({o_timeout, o_grant_vld} !== {(k == 8), (k != 8)})
            $display("FAIL tmo_fire_c%0d: tmo=%b vld=%b want %b %b", k, o_timeout, o_grant_vld,
                     (k == 8), (k != 8));
         else n_pass++;
      end
      tick;
      n_checks++;
      if (o_timeout !== 1'b0) $display("FAIL tmo_pulse_len: tmo=%b want 0", o_timeout);
      else n_pass++;
      i_req = 16'h0001;
      tick;
      i_req = '0;
      for (int k = 1; k <= 7; k++) tick;
      i_done = 1'b1;
      tick;
      i_done = 1'b0;
      n_checks++;
      if ({o_timeout, o_grant_vld} !== 2'b00)
         $display("FAIL tmo_done_wins: tmo=%b vld=%b want 0 0", o_timeout, o_grant_vld);
      else n_pass++;
      tick;
   endtask
`endif

   initial begin
      i_rst = 1'b1; i_req = '0; i_full = 1'b0; i_done = 1'b0;
      test_reset;
      test_single;
      test_rr_order;
      test_reject;
      test_full_during_busy;
      test_reset_mid_busy;
      test_done_idle;
      test_random;
`ifdef PORT_ARB_TIMEOUT_EN
      test_timeout;
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
